// File: rtl/dco_code_ctrl.sv
// ADPLL DCO tuning-word controller: a 6-step halving search from mid-scale, then
// saturating +/-1 tracking with a reversal-count lock detector.
module dco_code_ctrl #(
  parameter int unsigned SettleCyc = 16,
  parameter int unsigned LockCnt   = 8,
  parameter int unsigned MidLevel  = 64,
  parameter int unsigned MaxLevel  = 128
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         up_i,
  input  logic         dn_i,
  output logic [128:0] dco_code_o,
  output logic [7:0]   level_o,
  output logic         lock_o,
  output logic [1:0]   state_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StTrack  = 2'd2;

  localparam logic [1:0] DirNone = 2'd0;
  localparam logic [1:0] DirUp   = 2'd1;
  localparam logic [1:0] DirDn   = 2'd2;

  localparam logic [7:0] SampleCnt = 8'(SettleCyc - 1);
  localparam logic [3:0] LockCntL  = 4'(LockCnt);
  localparam logic [7:0] MidLevelL = 8'(MidLevel);
  localparam logic [7:0] MaxLevelL = 8'(MaxLevel);

  logic [1:0] state_q, state_d;
  logic [7:0] level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] step_q, step_d;
  logic [3:0] rev_q, rev_d;
  logic [1:0] last_q, last_d;
  logic       lock_q, lock_d;

  logic       is_sample;
  logic [1:0] dir;
  logic [3:0] rev_inc;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    rev_d   = rev_q;
    last_d  = last_q;
    lock_d  = lock_q;

    is_sample = (state_q != StIdle) && (cnt_q == SampleCnt);
    dir       = (up_i && !dn_i) ? DirUp : ((dn_i && !up_i) ? DirDn : DirNone);
    rev_inc   = (rev_q >= LockCntL) ? rev_q : rev_q + 4'd1;

    case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StSearch;
          level_d = MidLevelL;
          step_d  = 6'd32;
          cnt_d   = 8'd0;
          lock_d  = 1'b0;
        end
      end
      StSearch, StTrack: begin
        if (!en_i) begin
          // Disable wins over a coincident sample; the level is frozen.
          state_d = StIdle;
          lock_d  = 1'b0;
          cnt_d   = 8'd0;
        end else if (!is_sample) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (state_q == StSearch) begin
            if (dir == DirUp) level_d = level_q + {2'b00, step_q};
            else if (dir == DirDn) level_d = level_q - {2'b00, step_q};
            step_d = step_q >> 1;
            if (step_q == 6'd1) begin
              state_d = StTrack;
              rev_d   = 4'd0;
              last_d  = DirNone;
            end
          end else if (dir != DirNone) begin
            if (dir == DirUp && level_q != MaxLevelL) level_d = level_q + 8'd1;
            if (dir == DirDn && level_q != 8'd0) level_d = level_q - 8'd1;
            // Saturated decisions still feed the lock detector.
            last_d = dir;
            if (last_q == DirNone) begin
              rev_d = rev_q;
            end else if (dir != last_q) begin
              rev_d = rev_inc;
              if (rev_inc == LockCntL) lock_d = 1'b1;
            end else begin
              rev_d  = 4'd0;
              lock_d = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      level_q <= 8'd0;
      cnt_q   <= 8'd0;
      step_q  <= 6'd0;
      rev_q   <= 4'd0;
      last_q  <= DirNone;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    dco_code_o = '0;
    for (int i = 0; i < 129; i++) begin
      dco_code_o[i] = (8'(i) < level_q);
    end
  end

  assign level_o = level_q;
  assign lock_o  = lock_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Directed bench for dco_code_ctrl with a 4-cycle settle interval and LOCK_CNT=8.
module tb_dco_code_ctrl;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         up;
  logic         dn;
  logic [128:0] dco_code;
  logic [7:0]   level;
  logic         lock;
  logic [1:0]   state;

  int tests  = 0;
  int errors = 0;

  dco_code_ctrl #(
    .SettleCyc(4),
    .LockCnt  (8),
    .MidLevel (64),
    .MaxLevel (128)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .up_i      (up),
    .dn_i      (dn),
    .dco_code_o(dco_code),
    .level_o   (level),
    .lock_o    (lock),
    .state_o   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [128:0] therm(input int n);
    logic [128:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0;
    #12;
    rst_n = 1'b1;
    tick(1);
    for (int c = 0; c < 20; c++) begin
      tests++;
      if (level !== 8'd0 || dco_code !== '0 || state !== 2'd0 || lock !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: level=%0d state=%0d lock=%0b code=%h, want all 0",
                 c, level, state, lock, dco_code);
      end
      tick(1);
    end
  endtask

  task automatic test_search_up();
    logic [7:0] exp_lv [6] = '{8'd96, 8'd112, 8'd120, 8'd124, 8'd126, 8'd127};
    up = 1'b1; dn = 1'b0; en = 1'b1;
    tick(1);
    tests++;
    if (level !== 8'd64 || state !== 2'd1) begin
      errors++;
      $display("FAIL search_start: level=%0d state=%0d, want 64/1", level, state);
    end
    for (int k = 0; k < 6; k++) begin
      tick(4);
      tests++;
      if (level !== exp_lv[k]) begin
        errors++;
        $display("FAIL search_up step%0d: level=%0d, want %0d", k + 1, level, exp_lv[k]);
      end
    end
    tests++;
    if (state !== 2'd2 || dco_code !== therm(127)) begin
      errors++;
      $display("FAIL search_up_end: state=%0d code=%h, want 2 / 2^127-1", state, dco_code);
    end
  endtask

  task automatic test_track_saturation();
    for (int k = 0; k < 2; k++) begin
      tick(4);
      tests++;
      if (level !== 8'd128 || dco_code !== therm(128) || dco_code[128] !== 1'b0 || lock !== 1'b0)
      begin
        errors++;
        $display("FAIL sat_high k=%0d: level=%0d lock=%0b code=%h, want 128/0", k, level, lock,
                 dco_code);
      end
    end
    up = 1'b0; dn = 1'b1;
    tick(4 * 128);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (level !== 8'd0 || dco_code !== '0 || lock !== 1'b0 || state !== 2'd2) begin
        errors++;
        $display("FAIL sat_low k=%0d: level=%0d lock=%0b state=%0d, want 0/0/2", k, level, lock,
                 state);
      end
      tick(4);
    end
    en = 1'b0;
    tick(1);
    tests++;
    if (state !== 2'd0 || level !== 8'd0) begin
      errors++;
      $display("FAIL disable_idle: state=%0d level=%0d, want 0/0", state, level);
    end
  endtask

  task automatic test_search_pattern();
    logic [7:0] exp_lv [6] = '{8'd32, 8'd48, 8'd40, 8'd44, 8'd42, 8'd43};
    en = 1'b1; up = 1'b0; dn = 1'b1;
    tick(1);
    tests++;
    if (level !== 8'd64) begin
      errors++;
      $display("FAIL pattern_start: level=%0d, want 64", level);
    end
    for (int k = 0; k < 6; k++) begin
      dn = (k % 2 == 0);
      up = (k % 2 == 1);
      tick(4);
      tests++;
      if (level !== exp_lv[k]) begin
        errors++;
        $display("FAIL pattern step%0d: level=%0d, want %0d", k + 1, level, exp_lv[k]);
      end
    end
    tests++;
    if (state !== 2'd2 || $countones(dco_code) != 43 || dco_code !== therm(43)) begin
      errors++;
      $display("FAIL pattern_end: state=%0d ones=%0d, want 2/43", state, $countones(dco_code));
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_lv;
    logic       exp_lock;
    for (int i = 1; i <= 9; i++) begin
      up = (i % 2 == 1);
      dn = (i % 2 == 0);
      tick(4);
      exp_lv   = (i % 2 == 1) ? 8'd44 : 8'd43;
      exp_lock = (i == 9);
      tests++;
      if (level !== exp_lv || lock !== exp_lock) begin
        errors++;
        $display("FAIL lock dec%0d: level=%0d lock=%0b, want %0d/%0b", i, level, lock, exp_lv,
                 exp_lock);
      end
    end
    up = 1'b1; dn = 1'b0;
    tick(4);
    tests++;
    if (level !== 8'd45 || lock !== 1'b0) begin
      errors++;
      $display("FAIL lock_repeat: level=%0d lock=%0b, want 45/0", level, lock);
    end
  endtask

  task automatic test_en_drop_reset();
    up = 1'b1; dn = 1'b0;
    tick(3);
    en = 1'b0;
    tick(1);
    tests++;
    if (state !== 2'd0 || level !== 8'd45 || lock !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_sample: state=%0d level=%0d lock=%0b, want 0/45/0", state, level,
               lock);
    end
    tick(3);
    tests++;
    if (level !== 8'd45) begin
      errors++;
      $display("FAIL idle_hold: level=%0d, want 45", level);
    end
    en = 1'b1;
    tick(1);
    tests++;
    if (level !== 8'd64 || state !== 2'd1) begin
      errors++;
      $display("FAIL reenable: level=%0d state=%0d, want 64/1", level, state);
    end
    tick(6);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (level !== 8'd0 || dco_code !== '0 || state !== 2'd0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: level=%0d state=%0d code=%h, want 0", level, state, dco_code);
    end
    en = 1'b0;
    #10 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_search_up();
    test_track_saturation();
    test_search_pattern();
    test_lock();
    test_en_drop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
